// File: rtl/vital_energy_level.sv
// Saturating vital-energy integrator driven by the regulator's inc/dec/fast/setval strobes.
// Optional macro VITAL_ENERGY_HYST_EN adds hysteresis to the quantized level output.
module vital_energy_level #(
    parameter int WIDTH     = 8,
    parameter int SLOW_DIV  = 16,
    parameter int FAST_DIV  = 4,
    parameter int RESET_VAL = 128,
    parameter int SET_VAL   = 128,
    parameter int HYST      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             inc,
    input  logic             dec,
    input  logic             fast,
    input  logic             setval,
    output logic [WIDTH-1:0] level,
    output logic [1:0]       level_q,
    output logic             empty,
    output logic             full,
    output logic             tick
);

    localparam int PW = $clog2(SLOW_DIV);
    localparam logic [WIDTH-1:0] LVL_MAX   = '1;
    localparam logic [WIDTH-1:0] RESET_LVL = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] SET_LVL   = WIDTH'(SET_VAL);

    logic [PW-1:0]    presc;
    logic [31:0]      period_m1;
    logic             step;
    logic [WIDTH:0]   inc_sum;
    logic [WIDTH:0]   dec_sum;
    logic [WIDTH-1:0] level_next;
    logic [1:0]       q_next;

    // The >= test lets a late switch to fast mode step immediately instead of wrapping.
    assign period_m1 = fast ? 32'(FAST_DIV - 1) : 32'(SLOW_DIV - 1);
    assign step      = ena && !setval && (32'(presc) >= period_m1);

    assign inc_sum = {1'b0, level} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_sum = {1'b0, level} - {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        level_next = level;
        if (setval) begin
            level_next = SET_LVL;
        end else if (step) begin
            if (inc && !dec) begin
                level_next = inc_sum[WIDTH] ? LVL_MAX : inc_sum[WIDTH-1:0];
            end else if (dec && !inc) begin
                level_next = dec_sum[WIDTH] ? '0 : dec_sum[WIDTH-1:0];
            end
        end
    end

`ifdef VITAL_ENERGY_HYST_EN
    // Lower edge of band k is k quarters of the full range.
    function automatic logic [31:0] band_edge(input logic [1:0] k);
        band_edge = 32'(k) << (WIDTH - 2);
    endfunction

    logic [31:0] lvl_w;
    assign lvl_w = 32'(level_next);

    always_comb begin
        q_next = level_q;
        if (setval) begin
            q_next = SET_LVL[WIDTH-1:WIDTH-2];
        end else if ((level_q != 2'd3) &&
                     (lvl_w >= band_edge(level_q + 2'd1) + 32'(HYST))) begin
            q_next = level_q + 2'd1;
        end else if ((level_q != 2'd0) &&
                     (lvl_w + 32'(HYST) < band_edge(level_q))) begin
            q_next = level_q - 2'd1;
        end
    end
`else
    assign q_next = level_next[WIDTH-1:WIDTH-2];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level   <= RESET_LVL;
            presc   <= '0;
            tick    <= 1'b0;
            level_q <= RESET_LVL[WIDTH-1:WIDTH-2];
        end else begin
            tick  <= step;
            level <= level_next;
            if (setval) begin
                presc <= '0;
            end else if (ena) begin
                presc <= step ? '0 : presc + PW'(1);
            end
            if (setval || step) begin
                level_q <= q_next;
            end
        end
    end

    assign empty = (level == '0);
    assign full  = (level == LVL_MAX);

endmodule

// File: tb/tb_vital_energy_level.sv
// Directed bench for vital_energy_level: a behavioural model feeds a scoreboard queue,
// two instances (default SET_VAL and SET_VAL=254) are checked every cycle.
module tb_vital_energy_level;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena, inc, dec, fast, setval;
    logic [7:0] level_a, level_b;
    logic [1:0] q_a, q_b;
    logic       empty_a, empty_b, full_a, full_b, tick_a, tick_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int lvl;
        int q;
        int tk;
        int em;
        int fu;
    } exp_t;

    exp_t sb[$];

    int m_lvl[2];
    int m_q[2];
    int m_presc;
    int m_tick;

    always #5 clk = ~clk;

    vital_energy_level dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .inc(inc), .dec(dec), .fast(fast),
        .setval(setval), .level(level_a), .level_q(q_a), .empty(empty_a),
        .full(full_a), .tick(tick_a)
    );

    vital_energy_level #(.SET_VAL(254)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .inc(inc), .dec(dec), .fast(fast),
        .setval(setval), .level(level_b), .level_q(q_b), .empty(empty_b),
        .full(full_b), .tick(tick_b)
    );

    function automatic int set_of(int i);
        return (i == 0) ? 128 : 254;
    endfunction

    function automatic int q_model(int q_old, int v);
        int q;
`ifdef VITAL_ENERGY_HYST_EN
        q = q_old;
        if (q < 3 && v >= (q + 1) * 64 + 8) q = q + 1;
        else if (q > 0 && v < q * 64 - 8) q = q - 1;
`else
        q = v / 64;
        if (q_old < 0) q = 0;
`endif
        return q;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_lvl[i] = 128;
            m_q[i]   = 2;
        end
        m_presc = 0;
        m_tick  = 0;
    endtask

    task automatic model_step();
        int   p;
        exp_t e;
        p = fast ? 4 : 16;
        if (setval) begin
            m_presc = 0;
            m_tick  = 0;
            for (int i = 0; i < 2; i++) begin
                m_lvl[i] = set_of(i);
                m_q[i]   = set_of(i) / 64;
            end
        end else if (ena) begin
            if (m_presc >= p - 1) begin
                m_presc = 0;
                m_tick  = 1;
                for (int i = 0; i < 2; i++) begin
                    if (inc && !dec && m_lvl[i] < 255) m_lvl[i] = m_lvl[i] + 1;
                    else if (dec && !inc && m_lvl[i] > 0) m_lvl[i] = m_lvl[i] - 1;
                    m_q[i] = q_model(m_q[i], m_lvl[i]);
                end
            end else begin
                m_presc = m_presc + 1;
                m_tick  = 0;
            end
        end else begin
            m_tick = 0;
        end
        for (int i = 0; i < 2; i++) begin
            e.lvl = m_lvl[i];
            e.q   = m_q[i];
            e.tk  = m_tick;
            e.em  = (m_lvl[i] == 0) ? 1 : 0;
            e.fu  = (m_lvl[i] == 255) ? 1 : 0;
            sb.push_back(e);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        e = sb.pop_front();
        cmp("a.level", 32'(level_a), e.lvl);
        cmp("a.level_q", 32'(q_a), e.q);
        cmp("a.tick", 32'(tick_a), e.tk);
        cmp("a.empty", 32'(empty_a), e.em);
        cmp("a.full", 32'(full_a), e.fu);
        e = sb.pop_front();
        cmp("b.level", 32'(level_b), e.lvl);
        cmp("b.level_q", 32'(q_b), e.q);
        cmp("b.tick", 32'(tick_b), e.tk);
        cmp("b.empty", 32'(empty_b), e.em);
        cmp("b.full", 32'(full_b), e.fu);
    endtask

    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            model_step();
            @(posedge clk);
            #1;
            checkOutput();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        inc    = 1'b1;
        dec    = 1'b0;
        fast   = 1'b0;
        setval = 1'b0;
        model_reset();
        #12;
        cmp("reset.level", 32'(level_a), 128);
        cmp("reset.level_q", 32'(q_a), 2);
        cmp("reset.tick", 32'(tick_a), 0);
        cmp("reset.empty", 32'(empty_a), 0);
        cmp("reset.full", 32'(full_a), 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] slow increment");
        applyStimulus(15);
        cmp("t1.level_before", 32'(level_a), 128);
        applyStimulus(1);
        cmp("t1.level_16th", 32'(level_a), 129);
        cmp("t1.tick", 32'(tick_a), 1);
        cmp("t1.level_q", 32'(q_a), 2);
        applyStimulus(1);
        cmp("t1.tick_drop", 32'(tick_a), 0);

        $display("[TB] fast decrement after setval");
        setval = 1'b1;
        applyStimulus(1);
        setval = 1'b0;
        fast   = 1'b1;
        inc    = 1'b0;
        dec    = 1'b1;
        applyStimulus(4);
        cmp("t2.level_127", 32'(level_a), 127);
        cmp("t2.tick", 32'(tick_a), 1);
        applyStimulus(4);
        cmp("t2.level_126", 32'(level_a), 126);

        $display("[TB] saturation at full");
        setval = 1'b1;
        applyStimulus(1);
        setval = 1'b0;
        inc    = 1'b1;
        dec    = 1'b0;
        applyStimulus(4);
        cmp("t3.level_255", 32'(level_b), 255);
        cmp("t3.full", 32'(full_b), 1);
        applyStimulus(16);
        cmp("t3.level_hold", 32'(level_b), 255);
        cmp("t3.tick_sat", 32'(tick_b), 1);
        cmp("t3.level_a", 32'(level_a), 133);

        $display("[TB] fast rise past period and ena gap");
        fast   = 1'b0;
        setval = 1'b1;
        applyStimulus(1);
        setval = 1'b0;
        applyStimulus(10);
        fast = 1'b1;
        applyStimulus(1);
        cmp("t4.ge_step", 32'(tick_a), 1);
        applyStimulus(2);
        ena = 1'b0;
        applyStimulus(5);
        ena = 1'b1;
        applyStimulus(1);
        cmp("t4.no_step_yet", 32'(tick_a), 0);
        applyStimulus(1);
        cmp("t4.delayed_step", 32'(tick_a), 1);

        $display("[TB] setval without ena, async reset");
        fast   = 1'b0;
        setval = 1'b1;
        applyStimulus(1);
        setval = 1'b0;
        applyStimulus(7);
        ena    = 1'b0;
        setval = 1'b1;
        applyStimulus(1);
        cmp("t5.setval_level", 32'(level_a), 128);
        cmp("t5.setval_tick", 32'(tick_a), 0);
        setval = 1'b0;
        ena    = 1'b1;
        applyStimulus(15);
        cmp("t5.no_early_step", 32'(level_a), 128);
        applyStimulus(1);
        cmp("t5.step_level", 32'(level_a), 129);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        cmp("t5.async_level", 32'(level_a), 128);
        cmp("t5.async_tick", 32'(tick_a), 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] quantizer band crossing");
        fast   = 1'b1;
        setval = 1'b1;
        applyStimulus(1);
        setval = 1'b0;
        inc    = 1'b0;
        dec    = 1'b1;
        applyStimulus(72);
        cmp("t6.level_110", 32'(level_a), 110);
        cmp("t6.q_low", 32'(q_a), 1);
        inc = 1'b1;
        dec = 1'b0;
        applyStimulus(80);
        cmp("t6.level_130", 32'(level_a), 130);
`ifdef VITAL_ENERGY_HYST_EN
        cmp("t6.q_up_130", 32'(q_a), 1);
`else
        cmp("t6.q_up_130", 32'(q_a), 2);
`endif
        applyStimulus(40);
        cmp("t6.q_up_140", 32'(q_a), 2);
        inc = 1'b0;
        dec = 1'b1;
        applyStimulus(60);
        cmp("t6.level_125", 32'(level_a), 125);
`ifdef VITAL_ENERGY_HYST_EN
        cmp("t6.q_down_125", 32'(q_a), 2);
`else
        cmp("t6.q_down_125", 32'(q_a), 1);
`endif
        applyStimulus(40);
        cmp("t6.q_down_115", 32'(q_a), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vital_energy_level.md
Name: vital_energy_level

Overview:
Stateful integrator directly downstream of the vital-energy regulator. Consumes its inc/dec/fast/setval control strobes and holds the baby's vital energy as a saturating WIDTH-bit level. The level ramps at a slow or fast prescaled rate. Outputs the raw level, a 2-bit quantized level in the same encoding as the neurotransmitter fields (00 low … 11 high), saturation flags and an update tick for the sleep/action logic.

Parameters:
WIDTH, 8, level register width (≥3)
SLOW_DIV, 16, ena cycles per step when fast=0 (≥2)
FAST_DIV, 4, ena cycles per step when fast=1 (1 ≤ FAST_DIV ≤ SLOW_DIV)
RESET_VAL, 128, level after reset
SET_VAL, 128, level loaded on setval
HYST, 8, hysteresis margin in level units (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  global step enable (design tick); prescaler advances only when high
inc  in  1  request to increase energy (from regulator)
dec  in  1  request to decrease energy (from regulator)
fast  in  1  select FAST_DIV instead of SLOW_DIV
setval  in  1  synchronous load of SET_VAL
level  out  WIDTH  current energy level (registered)
level_q  out  2  quantized level (registered)
empty  out  1  level == 0
full  out  1  level == 2^WIDTH-1
tick  out  1  one-cycle pulse, high in the cycle the updated level first appears

Behaviour:
- Reset (async, rst_n=0): level=RESET_VAL, prescaler=0, tick=0, level_q=RESET_VAL[WIDTH-1:WIDTH-2]. empty and full are derived from the reset level.
- Prescaler width is $clog2(SLOW_DIV). Period P = fast ? FAST_DIV : SLOW_DIV, sampled every cycle.
- On each clock with ena=1 and setval=0: if prescaler ≥ P-1, a step occurs and the prescaler clears to 0. Otherwise the prescaler increments. The ≥ comparison matters when fast rises while the prescaler already exceeds FAST_DIV-1: the step is taken on the next ena cycle and the prescaler never wraps past P.
- ena=0: prescaler, level and level_q hold; tick=0.
- Step action: inc&!dec gives level+1, saturating at 2^WIDTH-1. dec&!inc gives level-1, saturating at 0. Both or neither: level holds. The prescaler still clears.
- tick is registered and high for exactly one cycle after every step edge, even when the level saturated or held. It is 0 otherwise.
- setval=1 has highest priority and is independent of ena. It loads level=SET_VAL, clears the prescaler and forces tick=0 that cycle. The next step is a full P ena-cycles later.
- empty/full: combinational decode of the level register only.
- level_q (feature off): registered copy of the top two bits of the next level, so it updates in the same cycle as level.
- No arithmetic wrap under any input sequence. All sums are computed at WIDTH+1 bits and clamped.
- Latency: inc/dec to level change takes 1 to P ena-cycles, depending on prescaler phase.

Optional Feature:
VITAL_ENERGY_HYST_EN
- Defined: level_q uses band thresholds T1=2^WIDTH/4, T2=2^WIDTH/2 and T3=3·2^WIDTH/4 with hysteresis.
  - level_q rises from band k to k+1 only when level ≥ T(k+1)+HYST.
  - level_q falls from band k to k-1 only when level < T(k)-HYST.
  - It moves at most one band per clock.
  - Reset value is computed from RESET_VAL without margin.
  - setval reinitialises level_q from SET_VAL without margin.
- Undefined: level_q = top two bits as above, and HYST is ignored.

Test Plan:
1. Default parameters, ena=1, inc=1, dec=0, fast=0 after reset → level 128→129 on the 16th clock; tick high one cycle; level_q=2'b10; empty=full=0.
2. setval pulse, then fast=1, dec=1 → level decrements every 4 clocks: 128, 127, 126…; tick every 4th cycle.
3. setval forced with SET_VAL=254 (override), fast=1, inc=1 for 20 clocks → level 255 after 4 clocks, then stays 255; full=1; tick keeps pulsing every 4 clocks.
4. inc=1, fast=0, prescaler at 10, then fast rises → step on the next clock (≥ rule); following steps every 4 clocks. ena toggled 0 for 5 cycles mid-count → step delayed by exactly 5 cycles.
5. Prescaler at 7, setval=1 with ena=0 → level=128 next clock, no tick; next step 16 ena-cycles later. Assert rst_n=0 asynchronously mid-count → level=128 and tick=0 immediately, without waiting for a clock.
6. Feature on, HYST=8, fast=1, ramp level up from 120 → level_q stays 01 until level=136, then 10. Ramp back down → level_q stays 10 until level=119, then 01. Feature off → transitions occur at 128 and 127.
